// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue: entry state encoding, entry record and
// pointer/index types at the default geometry.
package lsq_pkg;

  localparam int unsigned LSQ_N  = 16;
  localparam int unsigned LSQ_AW = 8;
  localparam int unsigned LSQ_DW = 8;
  localparam int unsigned LSQ_IW = $clog2(LSQ_N);

  typedef enum logic [2:0] {
    E_FREE,
    E_LD_ISSUE,
    E_LD_WAIT,
    E_LD_DONE,
    E_ST_PEND,
    E_ST_CMT
  } lsq_state_e;

  typedef logic [LSQ_IW-1:0] lsq_idx_t;
  typedef logic [LSQ_IW:0]   lsq_ptr_t;

  typedef struct packed {
    lsq_state_e          state;
    logic [LSQ_AW-1:0]   addr;
    logic [LSQ_DW-1:0]   data;
  } lsq_entry_t;

  function automatic logic lsq_is_store(input lsq_state_e s);
    return (s == E_ST_PEND) || (s == E_ST_CMT);
  endfunction

endpackage

// File: rtl/lsq_age_pick.sv
// Rotating-priority picker: oldest request at or after base, or (YOUNGEST) the
// youngest request strictly below base, walking backwards around the ring.
module lsq_age_pick #(
  parameter int unsigned N        = 16,
  parameter bit          YOUNGEST = 1'b0,
  localparam int unsigned IW      = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = YOUNGEST ? (base - IW'(i + 1)) : (base + IW'(i));
      if (!gnt_valid && req[pos]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos;
      end
    end
  end

endmodule

// File: rtl/lsq_ooo.sv
// Load/store queue: in-order allocation and retirement, store-to-load forwarding,
// tagged out-of-order memory reads and in-order committed store drain.
module lsq_ooo
  import lsq_pkg::*;
#(
  parameter int unsigned N   = LSQ_N,
  parameter int unsigned AW  = LSQ_AW,
  parameter int unsigned DW  = LSQ_DW,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_is_store,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  input  logic          store_commit,
  output logic          ld_valid,
  input  logic          ld_ready,
  output logic [DW-1:0] ld_data,
  output logic          mem_rd_valid,
  input  logic          mem_rd_ready,
  output logic [AW-1:0] mem_rd_addr,
  output logic [IW-1:0] mem_rd_id,
  input  logic          mem_rd_resp_valid,
  input  logic [IW-1:0] mem_rd_resp_id,
  input  logic [DW-1:0] mem_rd_resp_data,
  output logic          mem_wr_valid,
  input  logic          mem_wr_ready,
  output logic [AW-1:0] mem_wr_addr,
  output logic [DW-1:0] mem_wr_data,
  output logic [IW:0]   count,
  output logic          err_spurious
);

  typedef struct packed {
    lsq_state_e    state;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  localparam logic [IW:0] PTR_ONE = (IW+1)'(1);

  entry_t        q [N];
  logic [IW:0]   head, tail;
  logic [IW-1:0] head_idx, tail_idx;
  entry_t        hd;
  logic          alloc, pop;

  logic [N-1:0]  fwd_req, rd_req, cm_req;
  logic          fwd_found, rd_found, cm_found;
  logic [IW-1:0] fwd_idx, rd_idx, cm_idx;

  assign head_idx  = head[IW-1:0];
  assign tail_idx  = tail[IW-1:0];
  assign count     = tail - head;
  assign req_ready = !count[IW];
  assign alloc     = req_valid && req_ready;

  always_comb begin
    fwd_req = '0;
    rd_req  = '0;
    cm_req  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      fwd_req[IW'(i)] = lsq_is_store(q[IW'(i)].state) && (q[IW'(i)].addr == req_addr);
      rd_req[IW'(i)]  = (q[IW'(i)].state == E_LD_ISSUE);
      cm_req[IW'(i)]  = (q[IW'(i)].state == E_ST_PEND);
    end
  end

  // Only occupied entries can request, so scanning the full ring from tail
  // backwards (or head forwards) stays within head..tail-1.
  lsq_age_pick #(.N(N), .YOUNGEST(1'b1)) u_fwd_pick (
    .req       (fwd_req),
    .base      (tail_idx),
    .gnt_valid (fwd_found),
    .gnt_idx   (fwd_idx)
  );

  lsq_age_pick #(.N(N), .YOUNGEST(1'b0)) u_rd_pick (
    .req       (rd_req),
    .base      (head_idx),
    .gnt_valid (rd_found),
    .gnt_idx   (rd_idx)
  );

  lsq_age_pick #(.N(N), .YOUNGEST(1'b0)) u_cm_pick (
    .req       (cm_req),
    .base      (head_idx),
    .gnt_valid (cm_found),
    .gnt_idx   (cm_idx)
  );

  assign hd           = q[head_idx];
  assign ld_valid     = (hd.state == E_LD_DONE);
  assign ld_data      = ld_valid ? hd.data : '0;
  assign mem_wr_valid = (hd.state == E_ST_CMT);
  assign mem_wr_addr  = mem_wr_valid ? hd.addr : '0;
  assign mem_wr_data  = mem_wr_valid ? hd.data : '0;
  assign mem_rd_valid = rd_found;
  assign mem_rd_addr  = rd_found ? q[rd_idx].addr : '0;
  assign mem_rd_id    = rd_idx;
  assign pop          = (ld_valid && ld_ready) || (mem_wr_valid && mem_wr_ready);

  // Alloc never coincides with a pop of the same entry: req_ready is low when full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head         <= '0;
      tail         <= '0;
      err_spurious <= 1'b0;
      for (int unsigned i = 0; i < N; i++) q[IW'(i)] <= '0;
    end else begin
      if (mem_rd_valid && mem_rd_ready) q[rd_idx].state <= E_LD_WAIT;
      if (mem_rd_resp_valid) begin
        if (q[mem_rd_resp_id].state == E_LD_WAIT) begin
          q[mem_rd_resp_id].state <= E_LD_DONE;
          q[mem_rd_resp_id].data  <= mem_rd_resp_data;
        end else begin
          err_spurious <= 1'b1;
        end
      end
      if (store_commit && cm_found) q[cm_idx].state <= E_ST_CMT;
      if (pop) begin
        q[head_idx].state <= E_FREE;
        head              <= head + PTR_ONE;
      end
      if (alloc) begin
        q[tail_idx].addr <= req_addr;
        if (req_is_store) begin
          q[tail_idx].state <= E_ST_PEND;
          q[tail_idx].data  <= req_data;
        end else if (fwd_found) begin
          q[tail_idx].state <= E_LD_DONE;
          q[tail_idx].data  <= q[fwd_idx].data;
        end else begin
          q[tail_idx].state <= E_LD_ISSUE;
          q[tail_idx].data  <= '0;
        end
        tail <= tail + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_lsq_ooo.sv
// Scoreboard bench for lsq_ooo: expected load data and store writes are queued
// as stimulus is driven and compared as the queue retires them.
module tb_lsq_ooo;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_valid, req_ready, req_is_store;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          store_commit;
  logic          ld_valid, ld_ready;
  logic [DW-1:0] ld_data;
  logic          mem_rd_valid, mem_rd_ready;
  logic [AW-1:0] mem_rd_addr;
  logic [IW-1:0] mem_rd_id;
  logic          mem_rd_resp_valid;
  logic [IW-1:0] mem_rd_resp_id;
  logic [DW-1:0] mem_rd_resp_data;
  logic          mem_wr_valid, mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [IW:0]   count;
  logic          err_spurious;

  lsq_ooo #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_is_store      (req_is_store),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .store_commit      (store_commit),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_data           (ld_data),
    .mem_rd_valid      (mem_rd_valid),
    .mem_rd_ready      (mem_rd_ready),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_id         (mem_rd_id),
    .mem_rd_resp_valid (mem_rd_resp_valid),
    .mem_rd_resp_id    (mem_rd_resp_id),
    .mem_rd_resp_data  (mem_rd_resp_data),
    .mem_wr_valid      (mem_wr_valid),
    .mem_wr_ready      (mem_wr_ready),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .count             (count),
    .err_spurious      (err_spurious)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [DW-1:0]    exp_ld [$];
  logic [AW+DW-1:0] exp_wr [$];
  logic [IW+AW-1:0] rd_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (ld_valid && ld_ready) begin
        if (exp_ld.size() == 0) check_eq("ld_extra", 32'(ld_valid), 32'd0);
        else check_eq("ld_data", 32'(ld_data), 32'(exp_ld.pop_front()));
      end
      if (mem_wr_valid && mem_wr_ready) begin
        if (exp_wr.size() == 0) check_eq("wr_extra", 32'(mem_wr_valid), 32'd0);
        else check_eq("wr_addr_data", 32'({mem_wr_addr, mem_wr_data}), 32'(exp_wr.pop_front()));
      end
      if (mem_rd_valid && mem_rd_ready) rd_log.push_back({mem_rd_id, mem_rd_addr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int unsigned n;
    n = 0;
    req_valid    = 1'b1;
    req_is_store = st;
    req_addr     = a;
    req_data     = d;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_eq("req_ready_timeout", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic resp(input logic [IW-1:0] id, input logic [DW-1:0] d);
    mem_rd_resp_valid = 1'b1;
    mem_rd_resp_id    = id;
    mem_rd_resp_data  = d;
    tick();
    mem_rd_resp_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int unsigned n;
    n = 0;
    while (count != 0 && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(count), 32'd0);
  endtask

  task automatic wait_rd(input int unsigned k);
    int unsigned n;
    n = 0;
    while (rd_log.size() < k && n < 100) begin
      tick();
      n++;
    end
    check_eq("rd_issue_count", rd_log.size(), k);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = 1'b0;
    store_commit = 1'b0;
    mem_rd_resp_valid = 1'b0;
    tick();
    exp_ld.delete();
    exp_wr.delete();
    rd_log.delete();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    logic [IW+AW-1:0] e;
    logic [IW-1:0]    wid;
    req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_data = '0;
    store_commit = 1'b0; ld_ready = 1'b0; mem_rd_ready = 1'b1;
    mem_rd_resp_valid = 1'b0; mem_rd_resp_id = '0; mem_rd_resp_data = '0;
    mem_wr_ready = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_valids", 32'({ld_valid, mem_rd_valid, mem_wr_valid, err_spurious}), 32'd0);
    check_eq("rst_data", 32'({ld_data, mem_rd_addr, mem_rd_id, mem_wr_addr, mem_wr_data}), 32'd0);

    // Forwarding from the youngest matching store; load waits for both drains.
    push_op(1'b1, 8'h10, 8'hAB); exp_wr.push_back({8'h10, 8'hAB});
    push_op(1'b1, 8'h10, 8'hCD); exp_wr.push_back({8'h10, 8'hCD});
    push_op(1'b0, 8'h10, 8'h00); exp_ld.push_back(8'hCD);
    check_eq("fwd_no_rd", 32'(mem_rd_valid), 32'd0);
    check_eq("fwd_count", 32'(count), 32'd3);
    store_commit = 1'b1; tick(); store_commit = 1'b0;
    check_eq("cmt1_wr_valid", 32'(mem_wr_valid), 32'd1);
    check_eq("cmt1_ld_blocked", 32'(ld_valid), 32'd0);
    store_commit = 1'b1; tick(); store_commit = 1'b0;
    ld_ready = 1'b1; mem_wr_ready = 1'b1;
    wait_empty("fwd_drain");
    check_eq("fwd_rd_none", rd_log.size(), 32'd0);

    // Out-of-order responses, in-order retirement.
    do_reset();
    push_op(1'b0, 8'h01, 8'h00); exp_ld.push_back(8'h11);
    push_op(1'b0, 8'h02, 8'h00); exp_ld.push_back(8'h22);
    push_op(1'b0, 8'h03, 8'h00); exp_ld.push_back(8'h33);
    wait_rd(3);
    for (int unsigned k = 0; k < 3 && k < rd_log.size(); k++) begin
      e = rd_log[k];
      check_eq("rd_id_addr", 32'(e), 32'({IW'(k), AW'(k + 1)}));
    end
    resp(4'd2, 8'h33);
    check_eq("ooo_head_blocked", 32'(ld_valid), 32'd0);
    resp(4'd0, 8'h11);
    resp(4'd1, 8'h22);
    wait_empty("ooo_drain");
    check_eq("ooo_no_err", 32'(err_spurious), 32'd0);

    // Fill, full back-pressure, pop then alloc, forward from a popping store.
    do_reset();
    ld_ready = 1'b0; mem_wr_ready = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      push_op(1'b1, AW'(i), DW'(8'h40 + i));
      exp_wr.push_back({AW'(i), DW'(8'h40 + i)});
    end
    check_eq("full_count", 32'(count), 32'd16);
    check_eq("full_req_ready", 32'(req_ready), 32'd0);
    check_eq("full_tail_wrap", 32'(dut.tail), 32'h10);
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 8'h01;
    tick();
    check_eq("full_hold", 32'(count), 32'd16);
    store_commit = 1'b1; tick(); tick(); store_commit = 1'b0;
    mem_wr_ready = 1'b1;
    tick();
    check_eq("pop_count", 32'(count), 32'd15);
    check_eq("pop_req_ready", 32'(req_ready), 32'd1);
    exp_ld.push_back(8'h41);
    tick();
    req_valid = 1'b0; mem_wr_ready = 1'b0;
    check_eq("pop_alloc_count", 32'(count), 32'd15);
    check_eq("tail_after", 32'(dut.tail), 32'h11);
    ld_ready = 1'b1; mem_wr_ready = 1'b1;
    store_commit = 1'b1; repeat (14) tick(); store_commit = 1'b0;
    wait_empty("full_drain");

    // Spurious response to a FREE entry.
    ld_ready = 1'b0;
    rd_log.delete();
    push_op(1'b0, 8'h07, 8'h00); exp_ld.push_back(8'h77);
    wait_rd(1);
    resp(4'd5, 8'h99);
    check_eq("spur_err", 32'(err_spurious), 32'd1);
    check_eq("spur_count", 32'(count), 32'd1);
    tick();
    check_eq("spur_sticky", 32'(err_spurious), 32'd1);
    wid = (rd_log.size() > 0) ? rd_log[0][IW+AW-1:AW] : '0;
    check_eq("wrap_rd_id", 32'(wid), 32'd1);
    resp(wid, 8'h77);
    ld_ready = 1'b1;
    wait_empty("spur_drain");
    check_eq("spur_sticky2", 32'(err_spurious), 32'd1);

    // Commit with nothing pending, and commit coinciding with allocation.
    do_reset();
    check_eq("rst_err_clear", 32'(err_spurious), 32'd0);
    mem_wr_ready = 1'b1;
    store_commit = 1'b1; tick(); store_commit = 1'b0;
    store_commit = 1'b1;
    push_op(1'b1, 8'h20, 8'h5A);
    store_commit = 1'b0;
    tick(); tick();
    check_eq("no_cmt_wr_valid", 32'(mem_wr_valid), 32'd0);
    check_eq("no_cmt_count", 32'(count), 32'd1);
    exp_wr.push_back({8'h20, 8'h5A});
    store_commit = 1'b1; tick(); store_commit = 1'b0;
    wait_empty("cmt_drain");

    // Reset with outstanding loads; late responses are spurious.
    do_reset();
    ld_ready = 1'b1;
    push_op(1'b0, 8'h31, 8'h00);
    push_op(1'b0, 8'h32, 8'h00);
    push_op(1'b0, 8'h33, 8'h00);
    wait_rd(3);
    check_eq("outst_count", 32'(count), 32'd3);
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    check_eq("mid_rst_valids", 32'({ld_valid, mem_rd_valid, mem_wr_valid, err_spurious}), 32'd0);
    check_eq("mid_rst_data", 32'({ld_data, mem_rd_addr, mem_rd_id}), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    resp(4'd0, 8'h12);
    check_eq("late_resp_err", 32'(err_spurious), 32'd1);
    check_eq("late_resp_count", 32'(count), 32'd0);

    check_eq("ld_queue_left", exp_ld.size(), 32'd0);
    check_eq("wr_queue_left", exp_wr.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
